pal_cfg_streamer: RTL and testbench
===================================

// Module: pal_cfg_streamer
// PURPOSE
//  Transmit side of the PAL serial configuration port. Accepts config bytes on a
//  valid/ready stream and serialises them MSB-first onto cfg_bit, with a divided
//  cfg_clk and a final apply phase that raises cfg_en.
//  Sits between the on-chip config source (SPI/UART bridge or ROM) and the PAL
//  clock/cfg/en pins.
// PARAMETERS
//  CFG_BITS  242  total config bits (2*8*11 AND plane + 11*6 OR plane); >=1
//  CLK_DIV   4    clk cycles per cfg_clk phase (low, then high); >=1
// PORTS
//  clk      in   1  system clock, all logic on rising edge
//  rst      in   1  synchronous reset, active-high
//  start    in   1  1-cycle request to begin a load; ignored unless IDLE
//  abort    in   1  return to IDLE at next edge; overrides everything but rst
//  s_data   in   8  config byte, MSB shifted first
//  s_valid  in   1  s_data valid
//  s_ready  out  1  byte accepted when s_valid & s_ready
//  busy     out  1  high in LOAD/SHIFT/APPLY
//  done     out  1  1-cycle pulse on APPLY->IDLE
//  cfg_clk  out  1  PAL config clock; PAL samples cfg_bit/cfg_en on its rise
//  cfg_bit  out  1  serial config data
//  cfg_en   out  1  PAL apply/enable; high only in APPLY and after done
// BEHAVIOUR
//  Reset: state=IDLE; s_ready=0, busy=0, done=0, cfg_clk=0, cfg_bit=0, cfg_en=0;
//  bit counter, div counter and both byte registers cleared.
//  Reset mid-load: PAL retains a partial chain; cfg_en=0 keeps it unapplied.
//  Datapath: shift reg (current byte) + 1-byte holding reg. s_ready=1 in
//  LOAD/SHIFT while holding reg empty and bytes still owed.
//  Bytes owed = ceil(CFG_BITS/8). Final byte: only top (CFG_BITS mod 8) bits are
//  sent when CFG_BITS%8!=0; remaining low bits are discarded.
//  States:
//   IDLE  : cfg_clk=0; cfg_en holds prior value. start -> LOAD, cfg_en<=0.
//   LOAD  : wait for first byte; handshake -> SHIFT, shift<=s_data,
//           cfg_bit<=s_data[7].
//   SHIFT : per bit: cfg_clk low CLK_DIV cycles, then high CLK_DIV cycles
//           (2*CLK_DIV per bit). cfg_bit stable for the whole bit period and
//           changes only on the cycle cfg_clk falls. After the 8th bit of a
//           byte, load next byte from holding reg; if holding reg empty
//           (underrun), stall with cfg_clk=0, cfg_bit held, no timeout.
//           After bit CFG_BITS-1's high phase -> APPLY.
//   APPLY : cfg_bit=0, cfg_en=1; one cfg_clk pulse (CLK_DIV low, CLK_DIV
//           high); then -> IDLE, done=1 for 1 cycle; cfg_en stays 1.
//  Min latency start->done = 1 + (CFG_BITS+1)*2*CLK_DIV cycles, with bytes
//  offered back-to-back.
//  abort in any non-IDLE state: -> IDLE next edge; cfg_clk=0, cfg_en=0;
//  byte regs flushed; done not pulsed. abort in IDLE clears cfg_en.
//  start & abort same cycle: abort wins. start while busy: ignored.
//  Extra bytes beyond bytes owed are not accepted (s_ready=0).
//  Counters wrap-free: bit counter width clog2(CFG_BITS+1); div counter
//  resets every phase.
// TESTING
//  T1 CFG_BITS=16,CLK_DIV=2, bytes A5,3C back-to-back -> cfg_bit at 16 cfg_clk
//     rises = 1010_0101_0011_1100; cfg_en rise on 17th; done at cycle 69.
//  T2 CFG_BITS=12, bytes F0,B7 -> bits 1111_0000_1011 sent; low nibble of B7
//     never appears; exactly 12 data + 1 apply cfg_clk rises.
//  T3 underrun: withhold 2nd byte 20 cycles -> cfg_clk held 0 for stall,
//     cfg_bit stable, total duration +20 cycles, data correct.
//  T4 abort during SHIFT bit 5 -> next cycle busy=0, cfg_clk=0, cfg_en=0, no
//     done; new start reloads full chain correctly.
//  T5 rst asserted mid-SHIFT and mid-APPLY -> all outputs reset values next edge;
//     start/abort in same cycle from IDLE -> stays IDLE.
//  T6 default params, 31 random bytes, random s_valid gaps -> bench shift-reg
//     model of PAL chain matches first 242 bits; cfg_en=1 after done.

Source files
------------

// File: rtl/pal_cfg_streamer.sv
// pal_cfg_streamer: serialise config bytes MSB-first onto the PAL cfg_clk/cfg_bit/cfg_en pins
//   clk, rst            : clock, synchronous active-high reset
//   start, abort        : begin a load (IDLE only) / return to IDLE immediately
//   s_data/s_valid/s_ready : config byte stream
//   busy, done          : load in progress / 1-cycle completion pulse
//   cfg_clk, cfg_bit, cfg_en : PAL serial config pins
module pal_cfg_streamer #(
  parameter int CFG_BITS = 242,
  parameter int CLK_DIV  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       busy,
  output logic       done,
  output logic       cfg_clk,
  output logic       cfg_bit,
  output logic       cfg_en
);
  localparam int BYTES = (CFG_BITS + 7) / 8;
  localparam int BW = $clog2(CFG_BITS + 1);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int OW = $clog2(BYTES + 1);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, APPLY} state_t;
  state_t state, state_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [OW-1:0] owed, owed_n;
  logic [6:0] sh, sh_n;
  logic [7:0] hold, hold_n, nb;
  logic hi, hi_n, hold_v, hold_v_n, stall, stall_n, bit_n, en_n, done_n;
  logic hs, nb_v, ph_end, last, byte_end;
  assign s_ready = (state == LOAD || state == SHIFT) && !hold_v && owed != '0;
  assign busy = state != IDLE;
  assign cfg_clk = hi;
  assign hs = s_valid & s_ready;
  // next byte may come straight off the stream when the holding reg is empty
  assign nb_v = hold_v | hs;
  assign nb = hold_v ? hold : s_data;
  assign ph_end = int'(dcnt) == CLK_DIV - 1;
  assign last = int'(bcnt) == CFG_BITS - 1;
  assign byte_end = int'(bcnt) % 8 == 7;
  always_comb begin
    state_n = state;
    dcnt_n = dcnt;
    hi_n = hi;
    bcnt_n = bcnt;
    owed_n = hs ? owed - 1'b1 : owed;
    sh_n = sh;
    hold_n = hold;
    hold_v_n = hold_v;
    stall_n = stall;
    bit_n = cfg_bit;
    en_n = cfg_en;
    done_n = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = LOAD;
        en_n = 1'b0;
        owed_n = OW'(BYTES);
        bcnt_n = '0;
        dcnt_n = '0;
        hi_n = 1'b0;
      end
      LOAD: if (hs) begin
        state_n = SHIFT;
        sh_n = s_data[6:0];
        bit_n = s_data[7];
      end
      SHIFT: begin
        if (hs) begin
          hold_n = s_data;
          hold_v_n = 1'b1;
        end
        if (stall) begin
          if (nb_v) begin
            sh_n = nb[6:0];
            bit_n = nb[7];
            hold_v_n = 1'b0;
            stall_n = 1'b0;
          end
        end else if (!ph_end) dcnt_n = dcnt + 1'b1;
        else begin
          dcnt_n = '0;
          hi_n = !hi;
          if (hi) begin
            bcnt_n = bcnt + 1'b1;
            if (last) begin
              state_n = APPLY;
              bit_n = 1'b0;
              en_n = 1'b1;
            end else if (!byte_end) begin
              sh_n = {sh[5:0], 1'b0};
              bit_n = sh[6];
            end else if (nb_v) begin
              sh_n = nb[6:0];
              bit_n = nb[7];
              hold_v_n = 1'b0;
            end else stall_n = 1'b1;
          end
        end
      end
      default: if (!ph_end) dcnt_n = dcnt + 1'b1;
      else begin
        dcnt_n = '0;
        hi_n = !hi;
        if (hi) begin
          state_n = IDLE;
          done_n = 1'b1;
        end
      end
    endcase
    if (abort) begin
      state_n = IDLE;
      dcnt_n = '0;
      hi_n = 1'b0;
      owed_n = '0;
      sh_n = '0;
      hold_n = '0;
      hold_v_n = 1'b0;
      stall_n = 1'b0;
      bit_n = 1'b0;
      en_n = 1'b0;
      done_n = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dcnt <= '0;
      hi <= 1'b0;
      bcnt <= '0;
      owed <= '0;
      sh <= '0;
      hold <= '0;
      hold_v <= 1'b0;
      stall <= 1'b0;
      cfg_bit <= 1'b0;
      cfg_en <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      dcnt <= dcnt_n;
      hi <= hi_n;
      bcnt <= bcnt_n;
      owed <= owed_n;
      sh <= sh_n;
      hold <= hold_n;
      hold_v <= hold_v_n;
      stall <= stall_n;
      cfg_bit <= bit_n;
      cfg_en <= en_n;
      done <= done_n;
    end
  end
endmodule

// File: tb/tb_pal_cfg_streamer.sv
// tb_pal_cfg_streamer: three streamer instances (16/2, 12/2, 242/4) checked against a PAL chain model
module tb_pal_cfg_streamer;
  logic clk = 0, rst = 1;
  logic [2:0] start = '0, abort = '0, s_valid = '0;
  logic [7:0] s_data [3] = '{8'h0, 8'h0, 8'h0};
  logic [2:0] s_ready, busy, done, cfg_clk, cfg_bit, cfg_en;
  int total = 0, bad = 0, cyc = 0, t0 = 0;
  logic chain [3][$];
  int rise_c [3][$];
  int napply [3] = '{0, 0, 0};
  int glitch [3] = '{0, 0, 0};
  logic [2:0] pclk = '0, pbit = '0;
  logic [7:0] tx [$];
  int gaps [$];
  int base_b, base_a, base_g;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 3; g++) begin : u
    pal_cfg_streamer #(.CFG_BITS(g == 0 ? 16 : (g == 1 ? 12 : 242)), .CLK_DIV(g == 2 ? 4 : 2)) dut (
      .clk(clk), .rst(rst), .start(start[g]), .abort(abort[g]),
      .s_data(s_data[g]), .s_valid(s_valid[g]), .s_ready(s_ready[g]),
      .busy(busy[g]), .done(done[g]), .cfg_clk(cfg_clk[g]),
      .cfg_bit(cfg_bit[g]), .cfg_en(cfg_en[g]));
  end
  // PAL model: on each cfg_clk rise shift cfg_bit into the chain, or count an apply
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (cfg_clk[i] === 1'b1 && pclk[i] !== 1'b1) begin
        if (cfg_en[i]) napply[i]++;
        else chain[i].push_back(cfg_bit[i]);
        rise_c[i].push_back(cyc);
      end
      if (cfg_bit[i] !== pbit[i] && cfg_clk[i] === 1'b1) glitch[i]++;
      pclk[i] = cfg_clk[i];
      pbit[i] = cfg_bit[i];
    end
  end
  function automatic int nbits(int i);
    return i == 0 ? 16 : (i == 1 ? 12 : 242);
  endfunction
  function automatic int min_lat(int i);
    return 1 + (nbits(i) + 1) * 2 * (i == 2 ? 4 : 2);
  endfunction
  function automatic int chain_errs(int i, int base, int n);
    logic [7:0] b;
    int e = 0;
    if (chain[i].size() < base + n) return n;
    for (int k = 0; k < n; k++) begin
      b = tx[k / 8];
      if (chain[i][base + k] !== b[7 - k % 8]) e++;
    end
    return e;
  endfunction
  task automatic mark(input int i);
    base_b = chain[i].size();
    base_a = napply[i];
    base_g = glitch[i];
  endtask
  task automatic quick_start(input int i, input logic [7:0] b0, input logic [7:0] b1);
    @(posedge clk); #1;
    s_data[i] = b0; s_valid[i] = 1; start[i] = 1;
    @(posedge clk); #1;
    start[i] = 0; t0 = cyc;
    tx.delete(); tx.push_back(b0); tx.push_back(b1);
    mark(i);
    @(posedge clk); #1;
    s_data[i] = b1;
    @(posedge clk); #1;
    s_valid[i] = 0;
  endtask
  task automatic wait_done(input int i, output int lat);
    lat = -1;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (done[i]) begin
        lat = cyc - t0;
        break;
      end
    end
  endtask
  task automatic feed(input int i, output int lat);
    int tmo = 0;
    @(posedge clk); #1; start[i] = 1;
    @(posedge clk); #1; start[i] = 0; t0 = cyc;
    mark(i);
    fork
      begin
        for (int k = 0; k < tx.size(); k++) begin
          bit acc = 0;
          repeat (gaps[k]) begin @(posedge clk); #1; end
          s_data[i] = tx[k]; s_valid[i] = 1;
          for (int c = 0; c < 4000 && !acc; c++) begin
            @(negedge clk);
            if (s_ready[i]) acc = 1;
          end
          @(posedge clk); #1;
          s_valid[i] = 0;
          if (!acc) tmo++;
        end
      end
      wait_done(i, lat);
    join
    total++;
    if (tmo !== 0) begin bad++; $display("FAIL feed_accept inst%0d: %0d bytes never accepted, required 0", i, tmo); end
  endtask
  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({s_ready[i], busy[i], done[i], cfg_clk[i], cfg_bit[i], cfg_en[i]} !== 6'b0) begin
        bad++; $display("FAIL reset inst%0d: outs=%b required 000000", i, {s_ready[i], busy[i], done[i], cfg_clk[i], cfg_bit[i], cfg_en[i]});
      end
    end
    rst = 0;
  endtask
  task automatic test_basic;
    int lat;
    quick_start(0, 8'hA5, 8'h3C);
    s_data[0] = 8'hFF; s_valid[0] = 1;
    @(negedge clk);
    total++;
    if ({busy[0], s_ready[0]} !== 2'b10) begin bad++; $display("FAIL t1_extra_byte: busy,s_ready=%b required 10", {busy[0], s_ready[0]}); end
    wait_done(0, lat);
    s_valid[0] = 0;
    total++;
    if (lat !== 69) begin bad++; $display("FAIL t1_latency: got %0d required 69", lat); end
    total++;
    if (chain[0].size() - base_b !== 16 || chain_errs(0, base_b, 16) !== 0) begin
      bad++; $display("FAIL t1_chain: %0d bits, %0d wrong, required 16 bits 0 wrong", chain[0].size() - base_b, chain_errs(0, base_b, 16));
    end
    total++;
    if (napply[0] - base_a !== 1 || glitch[0] - base_g !== 0) begin
      bad++; $display("FAIL t1_apply: applies=%0d glitches=%0d required 1 0", napply[0] - base_a, glitch[0] - base_g);
    end
    @(negedge clk);
    total++;
    if ({done[0], busy[0], cfg_en[0], cfg_clk[0]} !== 4'b0010) begin
      bad++; $display("FAIL t1_after_done: done,busy,cfg_en,cfg_clk=%b required 0010", {done[0], busy[0], cfg_en[0], cfg_clk[0]});
    end
  endtask
  task automatic test_partial_byte;
    int lat;
    quick_start(1, 8'hF0, 8'hB7);
    wait_done(1, lat);
    total++;
    if (lat !== min_lat(1)) begin bad++; $display("FAIL t2_latency: got %0d required %0d", lat, min_lat(1)); end
    total++;
    if (chain[1].size() - base_b !== 12 || chain_errs(1, base_b, 12) !== 0) begin
      bad++; $display("FAIL t2_chain: %0d bits, %0d wrong, required 12 bits 0 wrong", chain[1].size() - base_b, chain_errs(1, base_b, 12));
    end
    total++;
    if (napply[1] - base_a !== 1) begin bad++; $display("FAIL t2_apply: applies=%0d required 1", napply[1] - base_a); end
  endtask
  task automatic test_underrun;
    int lat, r;
    tx.delete(); tx.push_back(8'($urandom)); tx.push_back(8'($urandom));
    gaps.delete(); gaps.push_back(0); gaps.push_back(51);
    r = rise_c[0].size();
    feed(0, lat);
    total++;
    if (lat !== 89) begin bad++; $display("FAIL t3_latency: got %0d required 89", lat); end
    total++;
    if (chain_errs(0, base_b, 16) !== 0 || glitch[0] - base_g !== 0) begin
      bad++; $display("FAIL t3_chain: wrong=%0d glitches=%0d required 0 0", chain_errs(0, base_b, 16), glitch[0] - base_g);
    end
    total++;
    if (rise_c[0].size() < r + 9 || rise_c[0][r + 8] - rise_c[0][r + 7] !== 24) begin
      bad++; $display("FAIL t3_stall_gap: rise spacing across stall wrong, required 24 cycles");
    end
  endtask
  task automatic test_abort;
    int lat, cnt = 0;
    logic [7:0] b0 = 8'($urandom);
    @(posedge clk); #1; abort[0] = 1;
    @(posedge clk); #1; abort[0] = 0;
    @(negedge clk);
    total++;
    if (cfg_en[0] !== 1'b0) begin bad++; $display("FAIL t4_idle_abort: cfg_en=%b required 0", cfg_en[0]); end
    quick_start(0, b0, 8'($urandom));
    repeat (20) begin @(posedge clk); #1; end
    abort[0] = 1;
    @(posedge clk); #1; abort[0] = 0;
    @(negedge clk);
    total++;
    if ({busy[0], cfg_clk[0], cfg_en[0], done[0], s_ready[0]} !== 5'b0) begin
      bad++; $display("FAIL t4_abort: busy,clk,en,done,ready=%b required 00000", {busy[0], cfg_clk[0], cfg_en[0], done[0], s_ready[0]});
    end
    total++;
    if (chain[0].size() - base_b !== 5 || chain_errs(0, base_b, 5) !== 0) begin
      bad++; $display("FAIL t4_partial: %0d bits sent, required 5 matching", chain[0].size() - base_b);
    end
    repeat (50) begin @(negedge clk); if (done[0]) cnt++; end
    total++;
    if (cnt !== 0) begin bad++; $display("FAIL t4_no_done: done seen %0d times required 0", cnt); end
    quick_start(0, 8'($urandom), 8'($urandom));
    wait_done(0, lat);
    total++;
    if (lat !== 69 || chain_errs(0, base_b, 16) !== 0) begin
      bad++; $display("FAIL t4_reload: lat=%0d wrong=%0d required 69 0", lat, chain_errs(0, base_b, 16));
    end
  endtask
  task automatic test_rst_mid;
    quick_start(0, 8'($urandom), 8'($urandom));
    repeat (8) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    total++;
    if ({s_ready[0], busy[0], done[0], cfg_clk[0], cfg_bit[0], cfg_en[0]} !== 6'b0) begin
      bad++; $display("FAIL t5_rst_shift: outs=%b required 000000", {s_ready[0], busy[0], done[0], cfg_clk[0], cfg_bit[0], cfg_en[0]});
    end
    quick_start(0, 8'($urandom), 8'($urandom));
    repeat (64) begin @(posedge clk); #1; end
    @(negedge clk);
    total++;
    if ({busy[0], cfg_en[0]} !== 2'b11) begin bad++; $display("FAIL t5_in_apply: busy,cfg_en=%b required 11", {busy[0], cfg_en[0]}); end
    rst = 1;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    total++;
    if ({s_ready[0], busy[0], done[0], cfg_clk[0], cfg_bit[0], cfg_en[0]} !== 6'b0) begin
      bad++; $display("FAIL t5_rst_apply: outs=%b required 000000", {s_ready[0], busy[0], done[0], cfg_clk[0], cfg_bit[0], cfg_en[0]});
    end
    @(posedge clk); #1; start[0] = 1; abort[0] = 1;
    @(posedge clk); #1; start[0] = 0; abort[0] = 0;
    @(negedge clk);
    total++;
    if ({busy[0], s_ready[0]} !== 2'b00) begin bad++; $display("FAIL t5_start_abort: busy,s_ready=%b required 00", {busy[0], s_ready[0]}); end
  endtask
  task automatic test_random_default;
    int lat;
    tx.delete(); gaps.delete();
    for (int k = 0; k < 31; k++) begin
      tx.push_back(8'($urandom));
      gaps.push_back($urandom_range(0, 3) == 0 ? $urandom_range(0, 45) : $urandom_range(0, 3));
    end
    feed(2, lat);
    total++;
    if (lat < min_lat(2)) begin bad++; $display("FAIL t6_latency: got %0d required >= %0d", lat, min_lat(2)); end
    total++;
    if (chain[2].size() - base_b !== 242 || chain_errs(2, base_b, 242) !== 0) begin
      bad++; $display("FAIL t6_chain: %0d bits, %0d wrong, required 242 bits 0 wrong", chain[2].size() - base_b, chain_errs(2, base_b, 242));
    end
    total++;
    if (napply[2] - base_a !== 1 || glitch[2] - base_g !== 0) begin
      bad++; $display("FAIL t6_apply: applies=%0d glitches=%0d required 1 0", napply[2] - base_a, glitch[2] - base_g);
    end
    @(negedge clk);
    total++;
    if ({done[2], busy[2], cfg_en[2]} !== 3'b001) begin bad++; $display("FAIL t6_after_done: done,busy,cfg_en=%b required 001", {done[2], busy[2], cfg_en[2]}); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_partial_byte;
    test_underrun;
    test_abort;
    test_rst_mid;
    test_random_default;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
